// File: rtl/bsc_if.sv
// bsc_if: host/config and status bundle for bounce_sweep_ctrl.
// The pause wire exists only when BSC_PAUSE_EN is defined.
interface bsc_if #(parameter int WIDTH = 3);
    logic             cfg_we;
    logic [WIDTH-1:0] cfg_lo;
    logic [WIDTH-1:0] cfg_hi;
    logic [7:0]       cfg_sweeps;
    logic             start;
    logic             stop;
`ifdef BSC_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             busy;
    logic             done;
    logic             err;
    modport master (
`ifdef BSC_PAUSE_EN
        output pause,
`endif
        output cfg_we, cfg_lo, cfg_hi, cfg_sweeps, start, stop,
        input  count, dir, busy, done, err
    );
    modport slave (
`ifdef BSC_PAUSE_EN
        input  pause,
`endif
        input  cfg_we, cfg_lo, cfg_hi, cfg_sweeps, start, stop,
        output count, dir, busy, done, err
    );
endinterface

// File: rtl/bounce_sweep_ctrl.sv
// bounce_sweep_ctrl: sweeps count lo->hi->lo with one-cycle dwell at each end, for N sweeps or forever.
// Optional BSC_PAUSE_EN adds a pause input that freezes a running sweep.
module bounce_sweep_ctrl #(
    parameter int WIDTH  = 3,
    parameter int DEF_LO = 0,
    parameter int DEF_HI = 5
) (
    input logic clk,
    input logic rst_n,
    bsc_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    localparam logic [WIDTH-1:0] ONE = 1;
    state_t state, state_n;
    logic [WIDTH-1:0] lo, hi, count, count_n;
    logic [7:0] sweeps, sweep_cnt, sweep_cnt_n;
    logic dir, dir_n, done, done_n, err, err_c, err_q, hold, run, last;
`ifdef BSC_PAUSE_EN
    assign hold = bus.pause;
`else
    assign hold = 1'b0;
`endif
    assign run  = state != IDLE;
    assign last = sweeps != 8'd0 && sweep_cnt + 8'd1 == sweeps;
    assign err_c = (run && bus.cfg_we) || (!run && bus.start && !bus.stop && lo >= hi);
    always_comb begin
        state_n     = state;
        count_n     = count;
        dir_n       = dir;
        sweep_cnt_n = sweep_cnt;
        done_n      = 1'b0;
        if (run && bus.stop) begin
            state_n = IDLE;
            count_n = lo;
            dir_n   = 1'b1;
        end else if (!run) begin
            if (bus.start && !bus.stop && lo < hi) begin
                state_n     = UP;
                count_n     = lo;
                dir_n       = 1'b1;
                sweep_cnt_n = 8'd0;
            end
        end else if (!hold) begin
            if (state == UP) begin
                count_n = count < hi ? count + ONE : count;
                state_n = count < hi ? UP : DOWN;
                dir_n   = count < hi;
            end else if (count > lo) begin
                count_n = count - ONE;
                // done is registered, so it is raised as count steps onto lo
                done_n  = last && count == lo + ONE;
            end else begin
                sweep_cnt_n = sweep_cnt == 8'hff ? sweep_cnt : sweep_cnt + 8'd1;
                state_n     = last ? IDLE : UP;
                dir_n       = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= WIDTH'(DEF_LO);
            dir       <= 1'b1;
            lo        <= WIDTH'(DEF_LO);
            hi        <= WIDTH'(DEF_HI);
            sweeps    <= 8'd0;
            sweep_cnt <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            dir       <= dir_n;
            sweep_cnt <= sweep_cnt_n;
            done      <= done_n;
            err       <= err_c && !err_q;
            err_q     <= err_c;
            if (!run && bus.cfg_we) begin
                lo     <= bus.cfg_lo;
                hi     <= bus.cfg_hi;
                sweeps <= bus.cfg_sweeps;
            end
        end
    end
    assign bus.count = count;
    assign bus.dir   = dir;
    assign bus.busy  = run;
    assign bus.done  = done;
    assign bus.err   = err;
endmodule

// File: tb/tb_bounce_sweep_ctrl.sv
// tb_bounce_sweep_ctrl: scoreboard bench; a position-based sweep model predicts every cycle's outputs.
// Define BSC_PAUSE_EN on both RTL and bench to exercise pause.
module tb_bounce_sweep_ctrl;
    localparam int W = 3;
    typedef struct {
        logic [W-1:0] count;
        logic dir, busy, done, err;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    exp_t q[$];
    bsc_if #(.WIDTH(W)) bus();
    bounce_sweep_ctrl #(.WIDTH(W), .DEF_LO(0), .DEF_HI(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // model: a run is a position p; each sweep is a period of 2*(hi-lo)+2 positions
    int m_run, m_p, m_sw, m_per, m_d, m_k;
    logic m_prev, m_ec, m_pz;
    logic [W-1:0] m_lo, m_hi, m_idle;
    exp_t e;
    always @(posedge clk) begin
        cyc_no++;
        if (!rst_n) begin
            m_run = 0; m_p = 0; m_sw = 0; m_prev = 1'b0;
            m_lo = 3'd0; m_hi = 3'd5; m_idle = 3'd0;
            e = '{count: 3'd0, dir: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0};
        end else begin
`ifdef BSC_PAUSE_EN
            m_pz = bus.pause;
`else
            m_pz = 1'b0;
`endif
            m_ec = (m_run != 0 && bus.cfg_we) || (m_run == 0 && bus.start && !bus.stop && m_lo >= m_hi);
            e.err = m_ec && !m_prev;
            m_prev = m_ec;
            e.done = 1'b0;
            m_per = 2 * (int'(m_hi) - int'(m_lo)) + 2;
            if (m_run != 0) begin
                if (bus.stop) begin
                    m_run = 0; m_idle = m_lo;
                end else if (!m_pz) begin
                    if (m_sw != 0 && m_p == m_sw * m_per - 1) begin
                        m_run = 0; m_idle = m_lo;
                    end else begin
                        m_p++;
                        e.done = m_sw != 0 && m_p == m_sw * m_per - 1;
                    end
                end
            end else begin
                if (bus.start && !bus.stop && m_lo < m_hi) begin
                    m_run = 1; m_p = 0;
                end
                if (bus.cfg_we) begin
                    m_lo = bus.cfg_lo; m_hi = bus.cfg_hi; m_sw = int'(bus.cfg_sweeps);
                end
            end
            if (m_run != 0) begin
                m_d = int'(m_hi) - int'(m_lo);
                m_per = 2 * m_d + 2;
                m_k = m_p % m_per;
                e.count = W'(m_k <= m_d ? int'(m_lo) + m_k : int'(m_lo) + m_per - 1 - m_k);
                e.dir = m_k <= m_d;
                e.busy = 1'b1;
            end else begin
                e.count = m_idle; e.dir = 1'b1; e.busy = 1'b0;
            end
        end
        q.push_back(e);
    end
    exp_t g;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            g = q.pop_front();
            checks++;
            if (bus.count !== g.count || bus.dir !== g.dir || bus.busy !== g.busy ||
                bus.done !== g.done || bus.err !== g.err) begin
                errors++;
                $display("FAIL outputs cycle %0d: got count=%0d dir=%b busy=%b done=%b err=%b, want count=%0d dir=%b busy=%b done=%b err=%b",
                         cyc_no, bus.count, bus.dir, bus.busy, bus.done, bus.err,
                         g.count, g.dir, g.busy, g.done, g.err);
            end
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic cfg(input int lo, input int hi, input int sw);
        bus.cfg_we = 1'b1; bus.cfg_lo = W'(lo); bus.cfg_hi = W'(hi); bus.cfg_sweeps = 8'(sw);
        cyc(1);
        bus.cfg_we = 1'b0;
    endtask
    task automatic go();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask
    task automatic wait_for(input int c, input logic d, input string name);
        int n = 0;
        while (!(bus.count == W'(c) && bus.dir == d) && n < 100) begin
            cyc(1);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s: count=%0d dir=%b never reached, want count=%0d dir=%b", name, bus.count, bus.dir, c, d);
        end
    endtask
    initial begin
        bus.cfg_we = 1'b0; bus.cfg_lo = '0; bus.cfg_hi = '0; bus.cfg_sweeps = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
`ifdef BSC_PAUSE_EN
        bus.pause = 1'b0;
`endif
        cyc(3);
        rst_n = 1'b1;
        cfg(0, 5, 1); go(); cyc(16);
        cfg(2, 4, 2); go(); cyc(16);
        cfg(3, 3, 1); go(); cyc(3);
        bus.start = 1'b1; cyc(3); bus.start = 1'b0; cyc(1);
        cfg(0, 5, 0); go(); cyc(20);
        wait_for(4, 1'b0, "t4_wait");
        bus.stop = 1'b1; cyc(1); bus.stop = 1'b0; cyc(3);
        cfg(0, 5, 1); go(); cyc(3);
        cfg(1, 5, 1); cyc(14);
        cfg(1, 5, 1); cyc(2);
        bus.stop = 1'b1; bus.start = 1'b1; cyc(1); bus.stop = 1'b0; bus.start = 1'b0; cyc(2);
`ifdef BSC_PAUSE_EN
        cfg(0, 5, 1); go();
        wait_for(5, 1'b1, "t6_wait");
        bus.pause = 1'b1; cyc(3); bus.pause = 1'b0; cyc(12);
`endif
        cfg(0, 5, 0); go(); cyc(5);
        #1 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        for (int i = 0; i < 3000; i++) begin
            bus.start = $urandom_range(0, 99) < 15;
            bus.stop = $urandom_range(0, 99) < 3;
            bus.cfg_we = !bus.start && $urandom_range(0, 99) < 6;
            bus.cfg_lo = W'($urandom_range(0, 7));
            bus.cfg_hi = W'($urandom_range(0, 7));
            bus.cfg_sweeps = 8'($urandom_range(0, 3));
`ifdef BSC_PAUSE_EN
            bus.pause = $urandom_range(0, 99) < 10;
`endif
            cyc(1);
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
